// File: rtl/alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_sequencer                                                 |
// | Purpose  : Command front-end for the registered 8-bit ALU; returns 6502  |
// |            N/V/Z/C flags and sequences two-pass 16-bit address adds.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_sequencer #(
    parameter int ALU_LATENCY  = 1,
    parameter int ENABLE_ADD16 = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [7:0]  req_a_hi,
    input  logic [7:0]  req_b_hi,
    input  logic        req_c_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  rsp_flag_mask,
    output logic        rsp_err,
    output logic [4:0]  alu_op,
    output logic [7:0]  alu_operand1,
    output logic [7:0]  alu_operand2,
    output logic        alu_carry,
    input  logic [7:0]  alu_result
);

    localparam logic [3:0] c_cmd_adc   = 4'd0;
    localparam logic [3:0] c_cmd_sbc   = 4'd1;
    localparam logic [3:0] c_cmd_and   = 4'd2;
    localparam logic [3:0] c_cmd_ora   = 4'd3;
    localparam logic [3:0] c_cmd_eor   = 4'd4;
    localparam logic [3:0] c_cmd_inc   = 4'd5;
    localparam logic [3:0] c_cmd_dec   = 4'd6;
    localparam logic [3:0] c_cmd_lsr   = 4'd7;
    localparam logic [3:0] c_cmd_asl   = 4'd8;
    localparam logic [3:0] c_cmd_ror   = 4'd9;
    localparam logic [3:0] c_cmd_rol   = 4'd10;
    localparam logic [3:0] c_cmd_cmp   = 4'd11;
    localparam logic [3:0] c_cmd_bit   = 4'd12;
    localparam logic [3:0] c_cmd_add16 = 4'd13;
    localparam logic [3:0] c_cmd_ld    = 4'd14;
    localparam logic [3:0] c_cmd_ill   = 4'd15;

    localparam logic [4:0] c_op_add = 5'd0;
    localparam logic [4:0] c_op_sub = 5'd1;
    localparam logic [4:0] c_op_and = 5'd2;
    localparam logic [4:0] c_op_or  = 5'd3;
    localparam logic [4:0] c_op_xor = 5'd4;
    localparam logic [4:0] c_op_inc = 5'd5;
    localparam logic [4:0] c_op_dec = 5'd6;
    localparam logic [4:0] c_op_shr = 5'd7;
    localparam logic [4:0] c_op_shl = 5'd8;
    localparam logic [4:0] c_op_rtr = 5'd9;
    localparam logic [4:0] c_op_rtl = 5'd10;
    localparam logic [4:0] c_op_ld  = 5'd12;

    localparam logic [3:0] c_mask_nvzc = 4'b1111;
    localparam logic [3:0] c_mask_nzc  = 4'b1011;
    localparam logic [3:0] c_mask_nvz  = 4'b1110;
    localparam logic [3:0] c_mask_nz   = 4'b1010;

    localparam logic [1:0] c_lat = 2'(ALU_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT     = 3'd2,
        S_ISSUE_HI = 3'd3,
        S_WAIT_HI  = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  a_hi_q, a_hi_d;
    logic [7:0]  b_hi_q, b_hi_d;
    logic        c_in_q, c_in_d;
    logic [7:0]  lo_q, lo_d;
    logic        c0_q, c0_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic [3:0]  rsp_mask_q, rsp_mask_d;
    logic        rsp_err_q, rsp_err_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic [7:0]  alu_op1_q, alu_op1_d;
    logic [7:0]  alu_op2_q, alu_op2_d;
    logic        alu_carry_q, alu_carry_d;

    logic        w_illegal;
    logic        w_adc_carry;
    logic        w_sbc_carry;
    logic        w_lo_carry;
    logic        w_hi_carry;
    logic [4:0]  w_op;
    logic [7:0]  w_op1;
    logic [7:0]  w_op2;
    logic        w_carry;
    logic        w_n, w_v, w_z, w_c;
    logic [3:0]  w_mask;
    logic [3:0]  w_flags;
    logic [15:0] w_res;

    assign w_illegal = (req_cmd == c_cmd_ill) ||
                       ((req_cmd == c_cmd_add16) && (ENABLE_ADD16 == 0));

    // Carries come from the latched operands; the ALU only supplies the result byte.
    assign w_adc_carry = ({1'b0, a_q} + {1'b0, b_q} + {8'd0, c_in_q}) > 9'd255;
    assign w_sbc_carry = {1'b0, a_q} >= ({1'b0, b_q} + {8'd0, ~c_in_q});
    assign w_lo_carry  = ({1'b0, a_q} + {1'b0, b_q}) > 9'd255;
    assign w_hi_carry  = ({1'b0, a_hi_q} + {1'b0, b_hi_q} + {8'd0, c0_q}) > 9'd255;

    always_comb begin
        w_op    = c_op_ld;
        w_op1   = a_q;
        w_op2   = b_q;
        w_carry = 1'b0;
        case (cmd_q)
            c_cmd_adc:   begin w_op = c_op_add; w_carry = c_in_q;  end
            c_cmd_sbc:   begin w_op = c_op_sub; w_carry = ~c_in_q; end
            c_cmd_cmp:   w_op = c_op_sub;
            c_cmd_and:   w_op = c_op_and;
            c_cmd_ora:   w_op = c_op_or;
            c_cmd_eor:   w_op = c_op_xor;
            c_cmd_bit:   w_op = c_op_and;
            c_cmd_inc:   begin w_op = c_op_inc; w_op1 = b_q; end
            c_cmd_dec:   begin w_op = c_op_dec; w_op1 = b_q; end
            c_cmd_lsr:   begin w_op = c_op_shr; w_carry = c_in_q; end
            c_cmd_asl:   begin w_op = c_op_shl; w_carry = c_in_q; end
            c_cmd_ror:   begin w_op = c_op_rtr; w_carry = c_in_q; end
            c_cmd_rol:   begin w_op = c_op_rtl; w_carry = c_in_q; end
            c_cmd_ld:    begin w_op = c_op_ld;  w_op1 = b_q; end
            c_cmd_add16: w_op = c_op_add;
            default:     w_op = c_op_ld;
        endcase
    end

    // Flags from sampled result; for ADD16 this is only meaningful on the high pass.
    always_comb begin
        w_n    = alu_result[7];
        w_v    = 1'b0;
        w_z    = (alu_result == 8'd0);
        w_c    = 1'b0;
        w_mask = c_mask_nz;
        w_res  = {8'd0, alu_result};
        case (cmd_q)
            c_cmd_adc: begin
                w_v    = (a_q[7] == b_q[7]) && (alu_result[7] != a_q[7]);
                w_c    = w_adc_carry;
                w_mask = c_mask_nvzc;
            end
            c_cmd_sbc: begin
                w_v    = (a_q[7] != b_q[7]) && (alu_result[7] != a_q[7]);
                w_c    = w_sbc_carry;
                w_mask = c_mask_nvzc;
            end
            c_cmd_cmp: begin
                w_z    = (a_q == b_q);
                w_c    = (a_q >= b_q);
                w_mask = c_mask_nzc;
                w_res  = 16'd0;
            end
            c_cmd_bit: begin
                w_n    = b_q[7];
                w_v    = b_q[6];
                w_z    = ((a_q & b_q) == 8'd0);
                w_mask = c_mask_nvz;
                w_res  = 16'd0;
            end
            c_cmd_lsr, c_cmd_ror: begin
                w_c    = a_q[0];
                w_mask = c_mask_nzc;
            end
            c_cmd_asl, c_cmd_rol: begin
                w_c    = a_q[7];
                w_mask = c_mask_nzc;
            end
            c_cmd_add16: begin
                w_res  = {alu_result, lo_q};
                w_z    = ({alu_result, lo_q} == 16'd0);
                w_c    = w_hi_carry;
                w_mask = c_mask_nzc;
            end
            default: w_mask = c_mask_nz;
        endcase
        w_flags = {w_n, w_v, w_z, w_c} & w_mask;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        a_d         = a_q;
        b_d         = b_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        c_in_d      = c_in_q;
        lo_d        = lo_q;
        c0_d        = c0_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_mask_d  = rsp_mask_q;
        rsp_err_d   = rsp_err_q;
        alu_op_d    = alu_op_q;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        alu_carry_d = alu_carry_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cmd_d  = req_cmd;
                    a_d    = req_a;
                    b_d    = req_b;
                    a_hi_d = req_a_hi;
                    b_hi_d = req_b_hi;
                    c_in_d = req_c_in;
                    if (w_illegal) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 16'd0;
                        rsp_flags_d = 4'd0;
                        rsp_mask_d  = 4'd0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                alu_op_d    = w_op;
                alu_op1_d   = w_op1;
                alu_op2_d   = w_op2;
                alu_carry_d = w_carry;
                cnt_d       = c_lat;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else if (cmd_q == c_cmd_add16) begin
                    lo_d    = alu_result;
                    c0_d    = w_lo_carry;
                    state_d = S_ISSUE_HI;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = w_res;
                    rsp_flags_d = w_flags;
                    rsp_mask_d  = w_mask;
                    alu_op_d    = c_op_ld;
                    alu_op1_d   = 8'd0;
                    alu_op2_d   = 8'd0;
                    alu_carry_d = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_ISSUE_HI: begin
                alu_op_d    = c_op_add;
                alu_op1_d   = a_hi_q;
                alu_op2_d   = b_hi_q;
                alu_carry_d = c0_q;
                cnt_d       = c_lat;
                state_d     = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = w_res;
                    rsp_flags_d = w_flags;
                    rsp_mask_d  = w_mask;
                    alu_op_d    = c_op_ld;
                    alu_op1_d   = 8'd0;
                    alu_op2_d   = 8'd0;
                    alu_carry_d = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered ready: it follows the state being entered, so RESP exit never accepts.
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            cmd_q       <= 4'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            a_hi_q      <= 8'd0;
            b_hi_q      <= 8'd0;
            c_in_q      <= 1'b0;
            lo_q        <= 8'd0;
            c0_q        <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_flags_q <= 4'd0;
            rsp_mask_q  <= 4'd0;
            rsp_err_q   <= 1'b0;
            alu_op_q    <= c_op_ld;
            alu_op1_q   <= 8'd0;
            alu_op2_q   <= 8'd0;
            alu_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            c_in_q      <= c_in_d;
            lo_q        <= lo_d;
            c0_q        <= c0_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_mask_q  <= rsp_mask_d;
            rsp_err_q   <= rsp_err_d;
            alu_op_q    <= alu_op_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            alu_carry_q <= alu_carry_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_flags     = rsp_flags_q;
    assign rsp_flag_mask = rsp_mask_q;
    assign rsp_err       = rsp_err_q;
    assign alu_op        = alu_op_q;
    assign alu_operand1  = alu_op1_q;
    assign alu_operand2  = alu_op2_q;
    assign alu_carry     = alu_carry_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_sequencer                                              |
// | Purpose  : Scoreboard bench for alu_sequencer with a registered ALU model|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_sequencer;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = 4'd0;
    logic [7:0]  req_a = 8'd0, req_b = 8'd0, req_a_hi = 8'd0, req_b_hi = 8'd0;
    logic        req_c_in = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags, rsp_flag_mask;
    logic        rsp_err;
    logic [4:0]  alu_op;
    logic [7:0]  alu_operand1, alu_operand2;
    logic        alu_carry;
    logic [7:0]  alu_result = 8'd0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;
        logic [3:0]  mask;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_sequencer #(.ALU_LATENCY(LAT), .ENABLE_ADD16(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b), .req_a_hi(req_a_hi), .req_b_hi(req_b_hi),
        .req_c_in(req_c_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_flag_mask(rsp_flag_mask), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_carry(alu_carry), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Single-register ALU; carry on SUB is a borrow.
    function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [7:0] x,
                                         input logic [7:0] y, input logic c);
        case (op)
            5'd0:    return x + y + {7'd0, c};
            5'd1:    return x - y - {7'd0, c};
            5'd2:    return x & y;
            5'd3:    return x | y;
            5'd4:    return x ^ y;
            5'd5:    return x + 8'd1;
            5'd6:    return x - 8'd1;
            5'd7:    return {1'b0, x[7:1]};
            5'd8:    return {x[6:0], 1'b0};
            5'd9:    return {c, x[7:1]};
            5'd10:   return {x[6:0], c};
            default: return x;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_f(alu_op, alu_operand1, alu_operand2, alu_carry);

    function automatic exp_t mk(input logic [15:0] d, input logic [3:0] f,
                                input logic [3:0] m, input logic e, input int l);
        exp_t r;
        r.data = d; r.flags = f; r.mask = m; r.err = e; r.lat = l;
        return r;
    endfunction

    // Reference behaviour of each command, written from the 6502 flag definitions.
    function automatic exp_t model(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] ah, input logic [7:0] bh, input logic c);
        logic [8:0] s;
        logic [8:0] sh;
        logic [7:0] r;
        logic n, v, z, cy;
        logic [3:0] m;
        logic [15:0] d;
        v = 1'b0; cy = 1'b0; m = 4'b1010; r = 8'd0;
        case (cmd)
            4'd0:  begin s = {1'b0, a} + {1'b0, b} + {8'd0, c}; r = s[7:0]; cy = s[8];
                         v = (a[7] == b[7]) && (r[7] != a[7]); m = 4'b1111; end
            4'd1:  begin r = a - b - {7'd0, !c}; cy = ({1'b0, a} >= ({1'b0, b} + {8'd0, !c}));
                         v = (a[7] != b[7]) && (r[7] != a[7]); m = 4'b1111; end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = b + 8'd1;
            4'd6:  r = b - 8'd1;
            4'd7:  begin r = a >> 1;          cy = a[0]; m = 4'b1011; end
            4'd8:  begin r = a << 1;          cy = a[7]; m = 4'b1011; end
            4'd9:  begin r = {c, a[7:1]};     cy = a[0]; m = 4'b1011; end
            4'd10: begin r = {a[6:0], c};     cy = a[7]; m = 4'b1011; end
            4'd14: r = b;
            default: r = 8'd0;
        endcase
        n = r[7]; z = (r == 8'd0); d = {8'd0, r};
        if (cmd == 4'd11) begin
            r = a - b; n = r[7]; z = (a == b); cy = (a >= b); m = 4'b1011; d = 16'd0;
        end
        if (cmd == 4'd12) begin
            n = b[7]; v = b[6]; z = ((a & b) == 8'd0); m = 4'b1110; d = 16'd0;
        end
        if (cmd == 4'd13) begin
            s  = {1'b0, a} + {1'b0, b};
            sh = {1'b0, ah} + {1'b0, bh} + {8'd0, s[8]};
            d  = {sh[7:0], s[7:0]}; n = d[15]; z = (d == 16'd0); cy = sh[8]; v = 1'b0; m = 4'b1011;
            return mk(d, {n, v, z, cy} & m, m, 1'b0, 2 * LAT + 4);
        end
        if (cmd == 4'd15) return mk(16'd0, 4'd0, 4'd0, 1'b1, -1);
        return mk(d, {n, v, z, cy} & m, m, 1'b0, LAT + 2);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller sits 1 time unit after a rising edge; returns 1 unit after the accept edge.
    task automatic send(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ah, input logic [7:0] bh, input logic c, input exp_t e);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        check_val("req_ready_before_send", 32'(req_ready), 32'd1);
        req_cmd = cmd; req_a = a; req_b = b; req_a_hi = ah; req_b_hi = bh; req_c_in = c;
        req_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   cyc;
        cyc = 0;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        while (!rsp_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (e.lat >= 0) check_val({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                req_cmd = 4'd14; req_b = 8'h5A; req_valid = 1'b1;
            end
            @(posedge clk); #1;
            check_val({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check_val({tag, "_hold_data"}, 32'(rsp_data), 32'(e.data));
            check_val({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        check_val({tag, "_data"},  32'(rsp_data), 32'(e.data));
        check_val({tag, "_flags"}, 32'(rsp_flags), 32'(e.flags));
        check_val({tag, "_mask"},  32'(rsp_flag_mask), 32'(e.mask));
        check_val({tag, "_err"},   32'(rsp_err), 32'(e.err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check_val({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rc;
        logic [7:0] ra, rb, rah, rbh;
        logic       rcin;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_data",  32'(rsp_data), 32'd0);
        check_val("rst_flags_mask_err", 32'({rsp_flags, rsp_flag_mask, rsp_err}), 32'd0);
        check_val("rst_alu_op", 32'(alu_op), 32'd12);
        check_val("rst_alu_operands", 32'({alu_operand1, alu_operand2, alu_carry}), 32'd0);
        reset = 1'b0;

        send(4'd0, 8'h50, 8'h50, 8'h00, 8'h00, 1'b0, mk(16'h00A0, 4'b1100, 4'b1111, 1'b0, 3));
        collect("adc", 0);
        send(4'd1, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1, mk(16'h00FF, 4'b1000, 4'b1111, 1'b0, 3));
        collect("sbc", 0);
        send(4'd11, 8'h40, 8'h40, 8'h00, 8'h00, 1'b0, mk(16'h0000, 4'b0011, 4'b1011, 1'b0, 3));
        collect("cmp", 0);
        send(4'd9, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, mk(16'h0080, 4'b1001, 4'b1011, 1'b0, 3));
        collect("ror", 0);
        send(4'd12, 8'h0F, 8'hC0, 8'h00, 8'h00, 1'b0, mk(16'h0000, 4'b1110, 4'b1110, 1'b0, 3));
        collect("bit", 0);
        send(4'd13, 8'hF0, 8'h20, 8'h12, 8'h00, 1'b0, mk(16'h1310, 4'b0000, 4'b1011, 1'b0, 6));
        collect("add16", 0);
        send(4'd13, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b1, mk(16'h0000, 4'b0011, 4'b1011, 1'b0, 6));
        collect("add16_wrap", 0);
        send(4'd0, 8'h10, 8'h22, 8'h00, 8'h00, 1'b1, mk(16'h0033, 4'b0000, 4'b1111, 1'b0, 3));
        collect("hold", 5);
        send(4'd15, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, mk(16'h0000, 4'b0000, 4'b0000, 1'b1, -1));
        collect("illegal", 0);

        // Reset in the middle of an ADD16 low-pass wait.
        send(4'd13, 8'hF0, 8'h20, 8'h12, 8'h00, 1'b0, mk(16'h1310, 4'b0000, 4'b1011, 1'b0, 6));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        check_val("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("midrst_req_ready", 32'(req_ready), 32'd1);
        check_val("midrst_alu_op", 32'(alu_op), 32'd12);
        repeat (8) @(posedge clk);
        #1;
        check_val("midrst_no_stale", 32'(rsp_valid), 32'd0);
        send(4'd0, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0, mk(16'h0002, 4'b0000, 4'b1111, 1'b0, 3));
        collect("post_rst_adc", 0);

        for (int k = 0; k < 24; k++) begin
            rc   = 4'($urandom_range(0, 15));
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rah  = 8'($urandom);
            rbh  = 8'($urandom);
            rcin = 1'($urandom);
            send(rc, ra, rb, rah, rbh, rcin, model(rc, ra, rb, rah, rbh, rcin));
            collect($sformatf("rnd%0d_cmd%0d", k, rc), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Front-end controller for the registered 8-bit ALU used by the CPU core. Accepts one arithmetic/logic command at a time over a valid/ready handshake and drives the ALU op and operand inputs. Waits the ALU's registered latency, then computes 6502 N/V/Z/C flags and returns result plus flags over a second valid/ready handshake. Also sequences two-pass 16-bit address adds (low byte, then high byte with carry) through the same 8-bit ALU.

Parameters:
ALU_LATENCY, 1, clock edges from operands driven to ALU result valid (ALU registers once); legal range 1..3.
ENABLE_ADD16, 1, 1 = ADD16 command supported; 0 = ADD16 reported as illegal.

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  command present
req_ready  out  1  high only in IDLE
req_cmd  in  4  0 ADC,1 SBC,2 AND,3 ORA,4 EOR,5 INC,6 DEC,7 LSR,8 ASL,9 ROR,10 ROL,11 CMP,12 BIT,13 ADD16,14 LD; 15 illegal
req_a  in  8  accumulator/first operand (ADD16: base low byte)
req_b  in  8  memory/second operand (ADD16: offset low byte)
req_a_hi  in  8  ADD16 base high byte
req_b_hi  in  8  ADD16 offset high byte
req_c_in  in  1  current carry flag
rsp_valid  out  1  response held until accepted
rsp_ready  in  1  consumer accepts response
rsp_data  out  16  result; [15:8]=0 except ADD16
rsp_flags  out  4  {N,V,Z,C}
rsp_flag_mask  out  4  1 = flag updated by this command
rsp_err  out  1  illegal command
alu_op  out  5  ALU op code (ADD0 SUB1 AND2 OR3 XOR4 INC5 DEC6 SHR7 SHL8 RTR9 RTL10 LD12)
alu_operand1  out  8  ALU operand 1
alu_operand2  out  8  ALU operand 2
alu_carry  out  1  ALU carry in
alu_result  in  8  registered ALU result

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, ISSUE_HI, WAIT_HI, RESP. All outputs registered.
- Reset (any state, incl. mid-command): state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_flag_mask=0, rsp_err=0, alu_op=12 (LD), alu operands=0, alu_carry=0. In-flight ALU result discarded.
- IDLE: on req_valid&req_ready latch all req_* and go ISSUE; req_ready drops next cycle. Illegal cmd (15, or 13 with ENABLE_ADD16=0): go directly RESP with rsp_err=1, mask=0, data=0.
- ISSUE: drive alu_*; load wait counter with ALU_LATENCY; go WAIT. WAIT: decrement each cycle; at 0 sample alu_result, compute flags, go RESP (or ISSUE_HI for ADD16).
- Latency: accept edge to rsp_valid = ALU_LATENCY+2 cycles (3 at default); ADD16 = 2*ALU_LATENCY+4 (6 at default).
- Mapping: ADC->ADD, carry=C_in. SBC->SUB, carry=~C_in (borrow). CMP->SUB, carry=0. AND/ORA/EOR/BIT->AND/OR/XOR/AND. INC/DEC->INC/DEC, operand1=req_b. LSR/ASL/ROR/ROL->SHR/SHL/RTR/RTL, operand1=req_a, alu_carry=C_in. LD->LD, operand1=req_b. ADD16 low->ADD, carry=0.
- Flags computed by this block from latched operands and sampled result r (ALU flag outputs unused):
  ADC: C=carry-out of a+b+C_in (9-bit), V=(a7==b7)&(r7!=a7), mask NVZC.
  SBC: C=({0,a} >= b+~C_in), V=(a7!=b7)&(r7!=a7), mask NVZC.
  CMP: C=(a>=b), N=r7, Z=(a==b), mask NZC; rsp_data=0.
  BIT: N=b7, V=b6, Z=((a&b)==0), mask NVZ; rsp_data=0.
  AND/ORA/EOR/INC/DEC/LD: N=r7, Z=(r==0), mask NZ.
  ASL/ROL: C=a7; LSR/ROR: C=a0; N, Z from r; mask NZC.
  ADD16: low pass carry c0; ISSUE_HI drives ADD a_hi,b_hi,carry=c0; C=carry-out of high pass, Z=(16-bit result==0), N=result bit15, mask NZC. Wrap at 16'hFFFF -> 16'h0000, C=1.
- Unmasked flag bits driven 0.
- RESP: rsp_valid=1, data/flags stable until rsp_valid&rsp_ready; then IDLE, req_ready=1 next cycle. No back-to-back accept in the RESP-exit cycle.
- req_* ignored outside IDLE; alu_op returns to LD after final sample.

Test Plan:
- ADC a=8'h50,b=8'h50,C_in=0 -> rsp_data=8'hA0, flags N=1 V=1 Z=0 C=0, mask 4'b1111, rsp_valid 3 cycles after accept.
- SBC a=8'h00,b=8'h01,C_in=1 -> data=8'hFF, N=1 V=0 Z=0 C=0; CMP a=8'h40,b=8'h40 -> Z=1 C=1 N=0, mask 4'b1011, data=0.
- ROR a=8'h01,C_in=1 -> data=8'h80, C=1 N=1 Z=0; BIT a=8'h0F,b=8'hC0 -> N=1 V=1 Z=1, mask 4'b1110.
- ADD16 base 16'h12F0 + 16'h0020 -> 16'h1310, C=0, latency 6; base 16'hFFFF + 16'h0001 -> 16'h0000, Z=1 C=1.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0, second req_valid not accepted; cmd 15 -> rsp_err=1, mask=0.
- Assert reset during WAIT of an ADD16 -> next cycle IDLE, rsp_valid=0, alu_op=12; a fresh ADC 8'h01+8'h01 then returns 8'h02 with no stale data.
